sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Shares the single SDRAM command/address/data bus between the init, auto-refresh, write and read
//  sub-FSMs of sdram_ctrl. Grants exactly one requester at a time and muxes its bus onto the pins.
//  Sits between fifo_ctrl (which raises wr/rd requests) and the SDRAM pads.
//  Refresh is never starved; write and read bursts are never pre-empted.
// PARAMETERS
//  ADDR_W   13       SDRAM row/col address width
//  BA_W     2        bank address width
//  DQ_W     16       data width
//  NOP_CMD  4'b0111  {cs_n,ras_n,cas_n,we_n} idle command
//  TMO_CYC  1023     max cycles a grant may stay open without its *_end pulse (10-bit counter)
// PORTS
//  sys_clk        in   1       system clock; all logic on rising edge
//  sys_rst        in   1       async active-high reset
//  init_end       in   1       level, init sequence complete
//  init_cmd       in   4       init FSM command; init_ba in BA_W, init_addr in ADDR_W
//  aref_req       in   1       level, refresh due
//  aref_end       in   1       pulse, refresh finished; aref_cmd 4 / aref_ba / aref_addr in
//  wr_req         in   1       level, write burst pending (sdram_wr_req)
//  wr_end         in   1       pulse, burst finished; wr_cmd 4 / wr_ba / wr_addr in
//  wr_dq          in   DQ_W    write data; wr_dq_oe in 1, drive enable
//  rd_req         in   1       level, read burst pending (sdram_rd_req)
//  rd_end         in   1       pulse, burst finished; rd_cmd 4 / rd_ba / rd_addr in
//  aref_en        out  1       grant level to refresh FSM
//  wr_en          out  1       grant level to write FSM
//  rd_en          out  1       grant level to read FSM
//  sdram_cmd      out  4       registered command to pads
//  sdram_ba       out  BA_W    registered bank; sdram_addr out ADDR_W registered address
//  sdram_dq_out   out  DQ_W    registered write data; sdram_dq_oe out 1 registered enable
//  arb_tmo        out  1       1-cycle pulse: grant aborted by timeout
// BEHAVIOUR
//  States: INIT, IDLE, AREF, WRITE, READ. Reset -> INIT.
//  - INIT: pins = init bus. init_end=1 -> IDLE next cycle. init_end ignored after leaving INIT.
//  - IDLE: priority aref_req > wr_req > rd_req (see CONFIGURATION). Winner entered next cycle.
//    No request -> stay; pins = NOP_CMD, ba/addr 0.
//  - AREF/WRITE/READ: matching *_en=1 for the whole state, combinational from state, so it
//    rises 1 cycle after the request is sampled in IDLE. Exits to IDLE on the matching *_end
//    pulse. *_en drops the cycle after *_end. Minimum 1 IDLE cycle between grants.
//  - No pre-emption: aref_req during WRITE/READ waits; it wins at the next IDLE.
//  - *_end of a non-granted requester is ignored.
//  - Pin mux: registered, 1-cycle latency from selected sub-FSM bus to sdram_cmd/ba/addr.
//    sdram_dq_oe=wr_dq_oe only in WRITE, else 0. sdram_dq_out=wr_dq in WRITE, else 0.
//  - Timeout: 10-bit counter cleared on grant entry, increments each granted cycle.
//    Reaching TMO_CYC without *_end -> IDLE, arb_tmo pulses 1 cycle, *_en drops.
//  - Reset values: state INIT, all *_en 0, sdram_cmd NOP_CMD, ba 0, addr 0, dq_out 0,
//    dq_oe 0, arb_tmo 0, counter 0. Reset mid-burst aborts at once; init_end is required again.
// CONFIGURATION
//  SDRAM_ARB_RR_EN defined: wr and rd alternate via a 1-bit last-grant flag (reset = read).
//  With both pending, the one not last served wins. Refresh keeps top priority.
//  Not defined: fixed priority aref > wr > rd.
// TESTING
//  1 Reset, init_end=0 for 50 cyc: state INIT, sdram_cmd follows init_cmd 1 cyc later.
//    Then init_end=1 -> IDLE, cmd=4'b0111.
//  2 IDLE, wr_req=1: wr_en=1 next cyc. wr_cmd=4'b0100 appears on sdram_cmd 1 cyc later.
//    wr_end pulse -> wr_en=0 next cyc.
//  3 aref_req, wr_req, rd_req raised same cycle: AREF granted first, then WRITE, then READ
//    (fixed). With RR_EN and last grant = write: READ before WRITE.
//  4 aref_req raised mid-READ: rd_en held until rd_end; aref_en rises 1 cyc after return to IDLE.
//  5 WRITE granted, wr_end never pulses: arb_tmo pulses at granted cycle 1023, wr_en=0,
//    state IDLE, dq_oe=0.
//  6 sys_rst asserted mid-WRITE with dq_oe=1: all outputs reach reset values asynchronously.
//    Release without init_end -> stays INIT.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Grants the SDRAM pin bus to one of the init/refresh/write/read sub-FSMs and registers the muxed bus onto the pads.
// Optional: define SDRAM_ARB_RR_EN for round-robin between write and read (refresh keeps top priority).
module sdram_arbiter #(
    parameter int          ADDR_W  = 13,
    parameter int          BA_W    = 2,
    parameter int          DQ_W    = 16,
    parameter logic [3:0]  NOP_CMD = 4'b0111,
    parameter int          TMO_CYC = 1023
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              arb_tmo
);

    typedef enum logic [2:0] {INIT, IDLE, AREF, WRITE, READ} state_t;

    state_t     state;
    state_t     idle_next;
    logic [9:0] tmo_cnt;
    logic       cur_end;
`ifdef SDRAM_ARB_RR_EN
    logic       last_wr;
`endif

    assign aref_en = (state == AREF);
    assign wr_en   = (state == WRITE);
    assign rd_en   = (state == READ);

    // Only the granted requester's end pulse can close the grant.
    always_comb begin
        cur_end = 1'b0;
        case (state)
            AREF:    cur_end = aref_end;
            WRITE:   cur_end = wr_end;
            READ:    cur_end = rd_end;
            default: cur_end = 1'b0;
        endcase
    end

    always_comb begin
        idle_next = IDLE;
        if (aref_req)
            idle_next = AREF;
`ifdef SDRAM_ARB_RR_EN
        else if (wr_req && rd_req)
            idle_next = last_wr ? READ : WRITE;
`endif
        else if (wr_req)
            idle_next = WRITE;
        else if (rd_req)
            idle_next = READ;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= INIT;
            tmo_cnt <= '0;
            arb_tmo <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_wr <= 1'b0;
`endif
        end else begin
            arb_tmo <= 1'b0;
            case (state)
                INIT: if (init_end) state <= IDLE;
                IDLE: begin
                    state   <= idle_next;
                    tmo_cnt <= '0;
`ifdef SDRAM_ARB_RR_EN
                    if (idle_next == WRITE)
                        last_wr <= 1'b1;
                    else if (idle_next == READ)
                        last_wr <= 1'b0;
`endif
                end
                default: begin
                    if (cur_end) begin
                        state <= IDLE;
                    end else if (tmo_cnt == 10'(TMO_CYC - 1)) begin
                        state   <= IDLE;
                        arb_tmo <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sdram_cmd    <= NOP_CMD;
            sdram_ba     <= '0;
            sdram_addr   <= '0;
            sdram_dq_out <= '0;
            sdram_dq_oe  <= 1'b0;
        end else begin
            sdram_dq_out <= '0;
            sdram_dq_oe  <= 1'b0;
            case (state)
                INIT: begin
                    sdram_cmd  <= init_cmd;
                    sdram_ba   <= init_ba;
                    sdram_addr <= init_addr;
                end
                AREF: begin
                    sdram_cmd  <= aref_cmd;
                    sdram_ba   <= aref_ba;
                    sdram_addr <= aref_addr;
                end
                WRITE: begin
                    sdram_cmd    <= wr_cmd;
                    sdram_ba     <= wr_ba;
                    sdram_addr   <= wr_addr;
                    sdram_dq_out <= wr_dq;
                    sdram_dq_oe  <= wr_dq_oe;
                end
                READ: begin
                    sdram_cmd  <= rd_cmd;
                    sdram_ba   <= rd_ba;
                    sdram_addr <= rd_addr;
                end
                default: begin
                    sdram_cmd  <= NOP_CMD;
                    sdram_ba   <= '0;
                    sdram_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: expected pin commands go through a scoreboard queue.
module tb_sdram_arbiter;

    localparam logic [3:0] NOP = 4'b0111;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic [15:0] wr_dq;
    logic        wr_dq_oe;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        arb_tmo;

    int tests = 0;
    int fails = 0;
    int n;
    logic [3:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    sdram_arbiter dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
        .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
        .wr_addr(wr_addr), .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
        .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .arb_tmo(arb_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    task automatic push_cmd(input logic [3:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_cmd(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty, observed %0h", tag, sdram_cmd);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(sdram_cmd), 32'(e));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en"},   32'({aref_en, wr_en, rd_en}), 32'd0);
        chk({tag, "_cmd"},  32'(sdram_cmd), 32'(NOP));
        chk({tag, "_ba"},   32'(sdram_ba), 32'd0);
        chk({tag, "_addr"}, 32'(sdram_addr), 32'd0);
        chk({tag, "_dq"},   32'(sdram_dq_out), 32'd0);
        chk({tag, "_oe"},   32'(sdram_dq_oe), 32'd0);
        chk({tag, "_tmo"},  32'(arb_tmo), 32'd0);
    endtask

    // Closes a granted write or read burst and waits out the mandatory idle cycle.
    task automatic finish_grant(input bit is_wr, input string tag);
        chk({tag, "_en"}, 32'(is_wr ? wr_en : rd_en), 32'd1);
        chk({tag, "_other"}, 32'(is_wr ? rd_en : wr_en), 32'd0);
        if (is_wr) begin wr_end = 1'b1; wr_req = 1'b0; end
        else       begin rd_end = 1'b1; rd_req = 1'b0; end
        cyc();
        chk({tag, "_drop"}, 32'({aref_en, wr_en, rd_en}), 32'd0);
        wr_end = 1'b0;
        rd_end = 1'b0;
        cyc();
    endtask

    initial begin
        sys_rst = 1'b1;
        init_end = 1'b0; init_cmd = 4'h0; init_ba = 2'd0; init_addr = '0;
        aref_req = 1'b0; aref_end = 1'b0; aref_cmd = 4'b0001; aref_ba = 2'd0; aref_addr = 13'h0400;
        wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'd3; wr_addr = 13'h1ABC;
        wr_dq = 16'hA5A5; wr_dq_oe = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'd1; rd_addr = 13'h0123;

        #1;
        chk_reset("rst");

        // 1: init passthrough for 50 cycles, then hand-off to idle
        cyc();
        sys_rst = 1'b0;
        init_ba = 2'd2;
        init_addr = 13'h0555;
        for (int i = 0; i < 50; i++) begin
            init_cmd = 4'(i);
            push_cmd(4'(i));
            cyc();
            pop_cmd("init_cmd");
        end
        chk("init_ba", 32'(sdram_ba), 32'd2);
        chk("init_addr", 32'(sdram_addr), 32'h555);
        chk("init_en", 32'({aref_en, wr_en, rd_en}), 32'd0);
        init_end = 1'b1;
        init_cmd = 4'hA;
        push_cmd(4'hA);
        cyc();
        pop_cmd("init_last");
        init_end = 1'b0;
        push_cmd(NOP);
        cyc();
        pop_cmd("idle_cmd");
        chk("idle_ba", 32'(sdram_ba), 32'd0);
        chk("idle_addr", 32'(sdram_addr), 32'd0);

        // 2: single write grant
        wr_req = 1'b1;
        wr_dq_oe = 1'b1;
        push_cmd(NOP);
        cyc();
        pop_cmd("wr_grant_cmd");
        chk("wr_grant_en", 32'(wr_en), 32'd1);
        wr_req = 1'b0;
        rd_end = 1'b1;
        push_cmd(4'b0100);
        cyc();
        pop_cmd("wr_cmd");
        chk("wr_foreign_end", 32'(wr_en), 32'd1);
        chk("wr_dq", 32'(sdram_dq_out), 32'hA5A5);
        chk("wr_oe", 32'(sdram_dq_oe), 32'd1);
        chk("wr_ba", 32'(sdram_ba), 32'd3);
        chk("wr_addr", 32'(sdram_addr), 32'h1ABC);
        rd_end = 1'b0;
        wr_end = 1'b1;
        push_cmd(4'b0100);
        cyc();
        pop_cmd("wr_end_cmd");
        chk("wr_end_en", 32'(wr_en), 32'd0);
        wr_end = 1'b0;
        push_cmd(NOP);
        cyc();
        pop_cmd("wr_post_cmd");
        chk("wr_post_oe", 32'(sdram_dq_oe), 32'd0);
        chk("wr_post_dq", 32'(sdram_dq_out), 32'd0);

        // 3: simultaneous requests
        aref_req = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        cyc();
        chk("pri_aref", 32'({aref_en, wr_en, rd_en}), 32'b100);
        aref_end = 1'b1;
        aref_req = 1'b0;
        cyc();
        chk("pri_gap", 32'({aref_en, wr_en, rd_en}), 32'd0);
        aref_end = 1'b0;
        cyc();
`ifdef SDRAM_ARB_RR_EN
        finish_grant(1'b0, "pri_rd_first");
        finish_grant(1'b1, "pri_wr_second");
`else
        finish_grant(1'b1, "pri_wr_first");
        finish_grant(1'b0, "pri_rd_second");
`endif

        // 4: refresh request during a read burst waits for rd_end
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        aref_req = 1'b1;
        push_cmd(4'b0101);
        cyc();
        pop_cmd("rd_cmd");
        chk("rd_ba", 32'(sdram_ba), 32'd1);
        chk("rd_hold1", 32'({aref_en, rd_en}), 32'b01);
        cyc();
        cyc();
        chk("rd_hold3", 32'({aref_en, rd_en}), 32'b01);
        rd_end = 1'b1;
        cyc();
        chk("rd_exit", 32'({aref_en, rd_en}), 32'b00);
        rd_end = 1'b0;
        cyc();
        chk("aref_after_rd", 32'(aref_en), 32'd1);
        aref_end = 1'b1;
        aref_req = 1'b0;
        push_cmd(4'b0001);
        cyc();
        pop_cmd("aref_cmd");
        chk("aref_addr", 32'(sdram_addr), 32'h400);
        chk("aref_exit", 32'(aref_en), 32'd0);
        aref_end = 1'b0;
        cyc();

        // 5: write grant with no wr_end is aborted after TMO_CYC granted cycles
        wr_req = 1'b1;
        wr_dq = 16'h1234;
        cyc();
        wr_req = 1'b0;
        chk("tmo_grant", 32'(wr_en), 32'd1);
        n = 1;
        while (wr_en === 1'b1 && n < 1100) begin
            cyc();
            if (wr_en === 1'b1) n++;
            if (n == 500) chk("tmo_early", 32'(arb_tmo), 32'd0);
        end
        chk("tmo_len", 32'(n), 32'd1023);
        chk("tmo_pulse", 32'(arb_tmo), 32'd1);
        chk("tmo_en", 32'({aref_en, wr_en, rd_en}), 32'd0);
        cyc();
        chk("tmo_pulse_end", 32'(arb_tmo), 32'd0);
        chk("tmo_oe", 32'(sdram_dq_oe), 32'd0);
        chk("tmo_idle", 32'(wr_en), 32'd0);

        // 6: asynchronous reset in the middle of a write burst
        wr_req = 1'b1;
        cyc();
        wr_req = 1'b0;
        cyc();
        chk("mid_oe", 32'(sdram_dq_oe), 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        chk_reset("async_rst");
        cyc();
        sys_rst = 1'b0;
        aref_req = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            init_cmd = 4'(3 + i);
            push_cmd(4'(3 + i));
            cyc();
            pop_cmd("reinit_cmd");
            chk("reinit_en", 32'({aref_en, wr_en, rd_en}), 32'd0);
        end
        aref_req = 1'b0;
        wr_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
